click_sync_arbiter: RTL and testbench
=====================================

Name: click_sync_arbiter

Overview:
- Clocked round-robin arbiter that shares one two-phase click output channel between two two-phase click requesters (A, B).
- Sits at the boundary where self-timed click pipelines (forks, joins) converge on a single downstream consumer, in a synchronous control island.
- Synchronizes incoming req/ack toggles, grants one requester at a time, forwards its data, and returns the ack toggle only after downstream acknowledges.
- Keeps per-requester grant counters for debug.

Parameters:
- DATA_WIDTH, 8, width of every data bus.
- PHASE_INIT, 0, reset value of all req/ack phase registers and synchronizer flops.
- SYNC_STAGES, 2, flop stages on each asynchronous req/ack input (minimum 2).
- CNT_WIDTH, 16, width of each saturating grant counter.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  reset; synchronous, active-low.
- inA_req  input  1  two-phase request toggle from requester A.
- inA_data  input  DATA_WIDTH  data from A; stable while A is pending.
- inA_ack  output  1  two-phase ack toggle to A.
- inB_req  input  1  two-phase request toggle from requester B.
- inB_data  input  DATA_WIDTH  data from B.
- inB_ack  output  1  two-phase ack toggle to B.
- out_req  output  1  two-phase request toggle to downstream.
- out_data  output  DATA_WIDTH  registered data of the granted requester.
- out_ack  input  1  two-phase ack toggle from downstream.
- busy  output  1  high while a transfer is outstanding (state WAIT_ACK).
- grant_cnt_a  output  CNT_WIDTH  completed A transfers, saturating.
- grant_cnt_b  output  CNT_WIDTH  completed B transfers, saturating.

Behaviour:
- Reset (rst_n low at a clk edge):
  - inA_ack, inB_ack, out_req and all synchronizer flops = PHASE_INIT.
  - out_data = 0; state = IDLE; last_grant = B (so A wins the first tie); counters = 0; busy = 0.
  - Reset asserted mid-transfer abandons the transfer with no ack toggle. Peers must be reset together.
- Synchronization: reqA_s, reqB_s, ack_s = inputs delayed SYNC_STAGES clocks.
- Pending: pendA = reqA_s != inA_ack; pendB = reqB_s != inB_ack.
- IDLE:
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the one that is not last_grant.
  - On the grant edge: out_data <= granted data; out_req <= !out_req; record the winner; go to WAIT_ACK.
  - If neither is pending, stay in IDLE.
- WAIT_ACK:
  - busy = 1; out_data and out_req are held.
  - When ack_s == out_req: toggle the winner's ack; last_grant <= winner; increment the winner's counter (saturates at all-ones, no wrap); go to IDLE.
- Latency:
  - A req toggle at edge 0 gives out_req toggle at edge SYNC_STAGES+1.
  - An out_ack toggle at edge k gives the requester ack toggle at edge k+SYNC_STAGES+1.
- Back-to-back: the other requester's pending, if still present, is granted on the edge immediately after returning to IDLE (one IDLE cycle between transfers).
- Re-pending: a just-released requester is not seen as pending again until its new req toggle has passed the synchronizer. No double-grant can occur from a stale req.
- Simultaneous pendA and pendB with last_grant = A: grant B. Strict alternation holds under continuous contention.
- Spurious out_ack toggle in IDLE: ignored, but it makes ack_s != out_req. Downstream protocol violation; the bench asserts it never happens.
- A transfer in WAIT_ACK is never preempted by a new request.

Decomposition:
- Package click_pkg:
  - state enum {IDLE, WAIT_ACK};
  - requester-id enum {REQ_A, REQ_B};
  - default constants for DATA_WIDTH and CNT_WIDTH.
- Sub-module click_sync: SYNC_STAGES-deep, 1-bit synchronizer with reset value PHASE_INIT. Instantiated three times (A req, B req, out ack).

Test Plan:
- Reset with PHASE_INIT=0, then A toggles req with data 0x5A -> out_req 0→1 at edge 3, out_data=0x5A. Downstream toggles out_ack -> inA_ack 0→1 three edges later; grant_cnt_a=1.
- A and B toggle req in the same cycle (data 0x11, 0x22) -> A is served first (out_data=0x11), then B (0x22) one IDLE cycle after A's ack; counters 1/1.
- Continuous contention for 8 transfers -> out_data alternates A,B,A,B...; each counter = 4; out_req toggles 8 times.
- Downstream withholds out_ack for 20 cycles -> busy=1 throughout; out_data stable; B's request waits; no ack toggle to A or B.
- rst_n low during WAIT_ACK -> next edge: state IDLE, all phases = PHASE_INIT, busy=0, counters 0, no ack toggle.
- CNT_WIDTH=2, 5 A transfers -> grant_cnt_a saturates at 3.

Source files
------------

// File: rtl/click_pkg.sv
// Shared types and default widths for the click round-robin arbiter.
package click_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Round-robin choice between the two requesters given their pending flags.
  function automatic req_id_e rr_pick(input logic pend_a, input logic pend_b,
                                      input req_id_e last_grant);
    if (pend_a && pend_b) begin
      return (last_grant == REQ_A) ? REQ_B : REQ_A;
    end
    return pend_a ? REQ_A : REQ_B;
  endfunction

endpackage

// File: rtl/click_sync_arbiter_if.sv
// Two-phase click handshake bundle: two upstream requesters and one downstream consumer.
interface click_sync_arbiter_if
  import click_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  inA_req;
  logic [DATA_WIDTH-1:0] inA_data;
  logic                  inA_ack;
  logic                  inB_req;
  logic [DATA_WIDTH-1:0] inB_data;
  logic                  inB_ack;
  logic                  out_req;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ack;

  // Arbiter side.
  modport slave (
    input  inA_req, inA_data, inB_req, inB_data, out_ack,
    output inA_ack, inB_ack, out_req, out_data
  );

  // Environment side: requesters plus downstream consumer.
  modport master (
    output inA_req, inA_data, inB_req, inB_data, out_ack,
    input  inA_ack, inB_ack, out_req, out_data
  );

endinterface

// File: rtl/click_sync.sv
// Multi-flop synchronizer for a single asynchronous phase bit.
module click_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          PHASE_INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Fewer than two stages gives no metastability protection.
  localparam int unsigned DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [DEPTH-1:0] stages_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages_q <= {DEPTH{PHASE_INIT}};
    end else begin
      stages_q <= {stages_q[DEPTH-2:0], d};
    end
  end

  assign q = stages_q[DEPTH-1];

endmodule

// File: rtl/click_sync_arbiter.sv
// Round-robin arbiter merging two two-phase click requesters onto one click output,
// with synchronized handshakes and saturating per-requester grant counters.
module click_sync_arbiter
  import click_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter bit          PHASE_INIT  = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  click_sync_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] grant_cnt_a,
  output logic [CNT_WIDTH-1:0] grant_cnt_b
);

  logic req_a_s;
  logic req_b_s;
  logic ack_s;

  click_sync #(.SYNC_STAGES(SYNC_STAGES), .PHASE_INIT(PHASE_INIT)) u_sync_req_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.inA_req),
    .q     (req_a_s)
  );

  click_sync #(.SYNC_STAGES(SYNC_STAGES), .PHASE_INIT(PHASE_INIT)) u_sync_req_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.inB_req),
    .q     (req_b_s)
  );

  click_sync #(.SYNC_STAGES(SYNC_STAGES), .PHASE_INIT(PHASE_INIT)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.out_ack),
    .q     (ack_s)
  );

  state_e                state_q,    state_d;
  req_id_e               winner_q,   winner_d;
  req_id_e               last_q,     last_d;
  logic                  out_req_q,  out_req_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  ack_a_q,    ack_a_d;
  logic                  ack_b_q,    ack_b_d;
  logic [CNT_WIDTH-1:0]  cnt_a_q,    cnt_a_d;
  logic [CNT_WIDTH-1:0]  cnt_b_q,    cnt_b_d;
  logic                  busy_q;

  logic    pend_a;
  logic    pend_b;
  req_id_e pick;

  // A requester is pending while its synchronized req phase differs from the ack we returned.
  assign pend_a = req_a_s ^ ack_a_q;
  assign pend_b = req_b_s ^ ack_b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winner_q   <= REQ_A;
      last_q     <= REQ_B;
      out_req_q  <= PHASE_INIT;
      out_data_q <= '0;
      ack_a_q    <= PHASE_INIT;
      ack_b_q    <= PHASE_INIT;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      busy_q     <= (state_d == WAIT_ACK);
    end
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    ack_a_d    = ack_a_q;
    ack_b_d    = ack_b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    pick       = rr_pick(pend_a, pend_b, last_q);

    case (state_q)
      IDLE: begin
        if (pend_a || pend_b) begin
          state_d    = WAIT_ACK;
          winner_d   = pick;
          out_req_d  = !out_req_q;
          out_data_d = (pick == REQ_A) ? bus.inA_data : bus.inB_data;
        end
      end
      WAIT_ACK: begin
        // Release the winner only once downstream has matched our request phase.
        if (ack_s == out_req_q) begin
          state_d = IDLE;
          last_d  = winner_q;
          if (winner_q == REQ_A) begin
            ack_a_d = !ack_a_q;
            if (cnt_a_q != '1) begin
              cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
            end
          end else begin
            ack_b_d = !ack_b_q;
            if (cnt_b_q != '1) begin
              cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.inA_ack  = ack_a_q;
  assign bus.inB_ack  = ack_b_q;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;
  assign busy         = busy_q;
  assign grant_cnt_a  = cnt_a_q;
  assign grant_cnt_b  = cnt_b_q;

endmodule

// File: tb/tb_click_sync_arbiter.sv
// Directed plus randomized bench for click_sync_arbiter against a transaction-level model.
module tb_click_sync_arbiter;
  import click_pkg::*;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Requester / downstream drive, shared by both arbiter instances.
  logic          a_req, b_req, dn_ack;
  logic [DW-1:0] a_data, b_data;

  click_sync_arbiter_if #(.DATA_WIDTH(DW)) bus1 ();
  click_sync_arbiter_if #(.DATA_WIDTH(DW)) bus2 ();

  assign bus1.inA_req  = a_req;
  assign bus1.inB_req  = b_req;
  assign bus1.inA_data = a_data;
  assign bus1.inB_data = b_data;
  assign bus1.out_ack  = dn_ack;
  assign bus2.inA_req  = a_req;
  assign bus2.inB_req  = b_req;
  assign bus2.inA_data = a_data;
  assign bus2.inB_data = b_data;
  assign bus2.out_ack  = dn_ack;

  logic        busy1, busy2;
  logic [15:0] ca1, cb1;
  logic [1:0]  ca2, cb2;

  click_sync_arbiter #(.DATA_WIDTH(DW), .PHASE_INIT(1'b0), .SYNC_STAGES(2), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus1),
    .busy        (busy1),
    .grant_cnt_a (ca1),
    .grant_cnt_b (cb1)
  );

  click_sync_arbiter #(.DATA_WIDTH(DW), .PHASE_INIT(1'b0), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus2),
    .busy        (busy2),
    .grant_cnt_a (ca2),
    .grant_cnt_b (cb2)
  );

  // Transaction-level model state.
  int      checks = 0;
  int      errors = 0;
  int      n_a, n_b;
  bit      m_ack_a, m_ack_b, m_out_req;
  req_id_e m_last, m_win;
  logic [DW-1:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // Expected winner from the round-robin rule over what the requesters have outstanding.
  function automatic req_id_e model_pick();
    bit pa, pb;
    pa = (a_req != m_ack_a);
    pb = (b_req != m_ack_b);
    if (pa && pb) return (m_last == REQ_A) ? REQ_B : REQ_A;
    return pa ? REQ_A : REQ_B;
  endfunction

  function automatic bit any_pending();
    return (a_req != m_ack_a) || (b_req != m_ack_b);
  endfunction

  task automatic model_reset();
    n_a = 0; n_b = 0;
    m_ack_a = 1'b0; m_ack_b = 1'b0; m_out_req = 1'b0;
    m_last = REQ_B;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_req"}, 32'(bus1.out_req), 32'(0));
    chk({tag, "_out_data"}, 32'(bus1.out_data), 32'(0));
    chk({tag, "_acks"}, 32'({bus1.inA_ack, bus1.inB_ack}), 32'(0));
    chk({tag, "_busy"}, 32'(busy1), 32'(0));
    chk({tag, "_cnt"}, {ca1, cb1}, 32'(0));
    chk({tag, "_cnt_sat"}, 32'({ca2, cb2}), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; dn_ack = 1'b0;
    step(2);
    model_reset();
    check_reset("reset");
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the next downstream request and check who was granted.
  task automatic grab(input string tag);
    int waited;
    waited = 0;
    m_win = model_pick();
    while (bus1.out_req === m_out_req && waited < 12) begin
      step(1);
      waited++;
    end
    chk({tag, "_grant"}, 32'(bus1.out_req), 32'(!m_out_req));
    m_out_req = !m_out_req;
    held = (m_win == REQ_A) ? a_data : b_data;
    chk({tag, "_data"}, 32'(bus1.out_data), 32'(held));
    chk({tag, "_busy"}, 32'(busy1), 32'(1));
  endtask

  // Downstream acknowledges after ack_delay cycles; requester ack must follow three edges later.
  task automatic finish(input int ack_delay, input string tag);
    step(ack_delay);
    chk({tag, "_no_spurious_ack"}, 32'(busy1), 32'(1));
    dn_ack = !dn_ack;
    step(2);
    chk({tag, "_ack_early"}, 32'({bus1.inA_ack, bus1.inB_ack}), 32'({m_ack_a, m_ack_b}));
    step(1);
    if (m_win == REQ_A) begin m_ack_a = !m_ack_a; n_a++; end
    else begin m_ack_b = !m_ack_b; n_b++; end
    m_last = m_win;
    chk({tag, "_ack"}, 32'({bus1.inA_ack, bus1.inB_ack}), 32'({m_ack_a, m_ack_b}));
    chk({tag, "_cnt"}, {ca1, cb1}, {16'(n_a), 16'(n_b)});
    chk({tag, "_cnt_sat"}, 32'({ca2, cb2}), 32'({2'(sat3(n_a)), 2'(sat3(n_b))}));
    chk({tag, "_idle"}, 32'(busy1), 32'(0));
  endtask

  task automatic serve(input int ack_delay, input string tag);
    grab(tag);
    finish(ack_delay, tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a_data = '0; b_data = '0;
    do_reset();

    // Single A transfer with exact request latency.
    a_data = 8'h5A;
    a_req  = !a_req;
    step(2);
    chk("t1_req_early", 32'(bus1.out_req), 32'(m_out_req));
    step(1);
    serve(0, "t1");

    // Simultaneous requests after reset: A first, then B after one idle cycle.
    do_reset();
    a_data = 8'h11; b_data = 8'h22;
    a_req = !a_req; b_req = !b_req;
    serve(1, "t2a");
    step(1);
    chk("t2_b2b", 32'(bus1.out_req), 32'(!m_out_req));
    serve(0, "t2b");

    // Continuous contention: strict alternation over 8 transfers.
    a_data = 8'($urandom); b_data = 8'($urandom);
    a_req = !a_req; b_req = !b_req;
    for (int i = 0; i < 8; i++) begin
      serve(int'($urandom_range(0, 2)), "t3");
      chk("t3_alt", 32'(m_win), 32'((i % 2 == 0) ? REQ_A : REQ_B));
      if (i < 7) begin
        if (m_win == REQ_A) begin a_data = 8'($urandom); a_req = !a_req; end
        else begin b_data = 8'($urandom); b_req = !b_req; end
      end
    end
    chk("t3_counts", {ca1, cb1}, {16'(5), 16'(5)});

    // Downstream stalls for 20 cycles while B waits.
    grab("t4");
    b_data = 8'($urandom);
    b_req  = !b_req;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t4_busy", 32'(busy1), 32'(1));
      chk("t4_data", 32'(bus1.out_data), 32'(held));
      chk("t4_acks", 32'({bus1.inA_ack, bus1.inB_ack}), 32'({m_ack_a, m_ack_b}));
    end
    finish(0, "t4");
    serve(0, "t4b");

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 3);
      if (sel == 0 && !any_pending()) sel = 1 + $urandom_range(0, 1);
      if (sel[0] && a_req == m_ack_a) begin a_data = 8'($urandom); a_req = !a_req; end
      if (sel[1] && b_req == m_ack_b) begin b_data = 8'($urandom); b_req = !b_req; end
      if (any_pending()) serve(int'($urandom_range(0, 4)), "rnd");
    end
    while (any_pending()) serve(0, "drain");
    step(6);
    chk("no_stale_grant", 32'(bus1.out_req), 32'(m_out_req));
    chk("no_stale_busy", 32'(busy1), 32'(0));

    // Reset during WAIT_ACK abandons the transfer.
    a_data = 8'hC3;
    a_req  = !a_req;
    grab("t5");
    step(3);
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; dn_ack = 1'b0;
    step(1);
    model_reset();
    check_reset("t5_rst");
    rst_n = 1'b1;
    step(4);
    chk("t5_quiet", 32'({bus1.out_req, bus1.inA_ack, bus1.inB_ack, busy1}), 32'(0));

    // Counter saturation on the narrow instance.
    for (int i = 0; i < 5; i++) begin
      a_data = 8'($urandom);
      a_req  = !a_req;
      serve(int'($urandom_range(0, 2)), "t6");
    end
    chk("t6_sat", 32'(ca2), 32'(3));
    chk("t6_wide", 32'(ca1), 32'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
